// File: rtl/flt_par_loader.sv
// Reloads the FLT coefficient memory: holds the filter in reset, flushes for a
// fixed number of cycles, then streams Len+1 handshaked words into addresses 0..Len.
module flt_par_loader #(
   parameter int ADDR_WIDTH   = 5,
   parameter int MEM_WIDTH    = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RI,
   input  logic                  Start_SI,
   input  logic [ADDR_WIDTH-1:0] Len_DI,
   input  logic                  Abort_SI,
   input  logic                  CofVld_SI,
   input  logic [MEM_WIDTH-1:0]  Cof_DI,
   output logic                  CofRdy_SO,
   output logic                  WrEn_SO,
   output logic [ADDR_WIDTH-1:0] Addr_DO,
   output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
   output logic                  FltRst_RBO,
   output logic                  Busy_SO,
   output logic                  Done_SO,
   output logic                  Abrt_SO
);

   typedef enum logic [1:0] {IDLE, FLUSH, LOAD, DONE} state_t;

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   state_t                state, state_nxt;
   logic [3:0]            flush_cnt, flush_cnt_nxt;
   logic [ADDR_WIDTH-1:0] word_cnt, word_cnt_nxt;
   logic [ADDR_WIDTH-1:0] len_q, len_nxt;
   logic                  cof_rdy, cof_rdy_nxt;
   logic                  wr_en, wr_en_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [MEM_WIDTH-1:0]  par_out, par_out_nxt;
   logic                  done, done_nxt;
   logic                  abrt, abrt_nxt;
   logic                  flt_rst_n, flt_rst_n_nxt;
   logic                  handshake;
   logic                  last_word;

   assign handshake = CofVld_SI & cof_rdy;
   assign last_word = (word_cnt == len_q);

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         state     <= IDLE;
         flush_cnt <= '0;
         word_cnt  <= '0;
         len_q     <= '0;
         cof_rdy   <= 1'b0;
         wr_en     <= 1'b0;
         addr      <= '0;
         par_out   <= '0;
         done      <= 1'b0;
         abrt      <= 1'b0;
         flt_rst_n <= 1'b0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         word_cnt  <= word_cnt_nxt;
         len_q     <= len_nxt;
         cof_rdy   <= cof_rdy_nxt;
         wr_en     <= wr_en_nxt;
         addr      <= addr_nxt;
         par_out   <= par_out_nxt;
         done      <= done_nxt;
         abrt      <= abrt_nxt;
         flt_rst_n <= flt_rst_n_nxt;
      end
   end

   // Abort wins over both the flush timeout and the final-word transition to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (Start_SI && !Abort_SI) state_nxt = FLUSH;
         FLUSH: begin
            if (Abort_SI)                     state_nxt = IDLE;
            else if (flush_cnt == FLUSH_LAST) state_nxt = LOAD;
         end
         LOAD: begin
            if (Abort_SI)                     state_nxt = IDLE;
            else if (handshake && last_word)  state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A handshake always completes its write, even when it coincides with an abort.
   always_comb begin
      flush_cnt_nxt = flush_cnt;
      word_cnt_nxt  = word_cnt;
      len_nxt       = len_q;
      wr_en_nxt     = handshake;
      addr_nxt      = handshake ? word_cnt : addr;
      par_out_nxt   = handshake ? Cof_DI : par_out;
      case (state)
         IDLE: begin
            if (Start_SI && !Abort_SI) begin
               len_nxt       = Len_DI;
               flush_cnt_nxt = '0;
               word_cnt_nxt  = '0;
            end
         end
         FLUSH:   if (flush_cnt != FLUSH_LAST) flush_cnt_nxt = flush_cnt + 4'd1;
         LOAD:    if (handshake && !last_word) word_cnt_nxt = word_cnt + 1'b1;
         default: ;
      endcase
      cof_rdy_nxt   = (state_nxt == LOAD);
      done_nxt      = (state_nxt == DONE);
      abrt_nxt      = Abort_SI && ((state == FLUSH) || (state == LOAD));
      flt_rst_n_nxt = (state_nxt == IDLE) && !wr_en_nxt;
   end

   assign CofRdy_SO  = cof_rdy;
   assign WrEn_SO    = wr_en;
   assign Addr_DO    = addr;
   assign PAR_Out_DO = par_out;
   assign FltRst_RBO = flt_rst_n;
   assign Busy_SO    = (state != IDLE);
   assign Done_SO    = done;
   assign Abrt_SO    = abrt;

endmodule

// File: tb/tb_flt_par_loader.sv
// Directed bench for flt_par_loader: reset, basic load, stall, abort, ignored
// requests, full address range, single word and reset during a load.
module tb_flt_par_loader;

   localparam int FL = 2;

   logic        Clk_CI = 1'b0;
   logic        Rst_RI = 1'b1;
   logic        Start_SI = 1'b0;
   logic [4:0]  Len_DI = '0;
   logic        Abort_SI = 1'b0;
   logic        CofVld_SI = 1'b0;
   logic [31:0] Cof_DI = '0;
   logic        CofRdy_SO, WrEn_SO, FltRst_RBO, Busy_SO, Done_SO, Abrt_SO;
   logic [4:0]  Addr_DO;
   logic [31:0] PAR_Out_DO;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int abrt_cnt = 0;
   int viol = 0;

   flt_par_loader #(.ADDR_WIDTH(5), .MEM_WIDTH(32), .FLUSH_CYCLES(FL)) dut (
      .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Start_SI(Start_SI), .Len_DI(Len_DI),
      .Abort_SI(Abort_SI), .CofVld_SI(CofVld_SI), .Cof_DI(Cof_DI),
      .CofRdy_SO(CofRdy_SO), .WrEn_SO(WrEn_SO), .Addr_DO(Addr_DO),
      .PAR_Out_DO(PAR_Out_DO), .FltRst_RBO(FltRst_RBO), .Busy_SO(Busy_SO),
      .Done_SO(Done_SO), .Abrt_SO(Abrt_SO)
   );

   always #5 Clk_CI = ~Clk_CI;

   // Event log sampled on the falling edge; tasks read it 1 ns later.
   always @(negedge Clk_CI) begin
      if (WrEn_SO === 1'b1) wr_cnt++;
      if (Done_SO === 1'b1) done_cnt++;
      if (Abrt_SO === 1'b1) abrt_cnt++;
      if (FltRst_RBO === 1'b1 && (Busy_SO === 1'b1 || WrEn_SO === 1'b1)) viol++;
   end

   task automatic step();
      @(negedge Clk_CI);
      #1;
   endtask

   task automatic start_load(input logic [4:0] len, output int fl_cycles);
      Len_DI = len;
      Start_SI = 1'b1;
      step();
      Start_SI = 1'b0;
      fl_cycles = 0;
      while (CofRdy_SO !== 1'b1 && fl_cycles < 20) begin
         fl_cycles++;
         step();
      end
   endtask

   task automatic send_word(input logic [31:0] data);
      CofVld_SI = 1'b1;
      Cof_DI = data;
      step();
      CofVld_SI = 1'b0;
   endtask

   task automatic test_reset();
      step();
      total++;
      if ({WrEn_SO, Addr_DO, PAR_Out_DO, CofRdy_SO, Busy_SO, Done_SO, Abrt_SO, FltRst_RBO} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_vals: got wr=%b addr=%0d par=%h rdy=%b busy=%b done=%b abrt=%b fltrst=%b, want all 0",
                  WrEn_SO, Addr_DO, PAR_Out_DO, CofRdy_SO, Busy_SO, Done_SO, Abrt_SO, FltRst_RBO);
      end
      Rst_RI = 1'b0;
      #1;
      total++;
      if (FltRst_RBO !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_low: got %b want 0", FltRst_RBO); end
      step();
      total++;
      if (FltRst_RBO !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_rise: got %b want 1", FltRst_RBO); end
   endtask

   task automatic test_basic_load();
      logic [31:0] w [4];
      int n, wr0, d0;
      w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
      wr0 = wr_cnt; d0 = done_cnt;
      start_load(5'd3, n);
      total++;
      if (n != FL) begin bad++; $display("[TB] FAIL basic_flush_len: got %0d want %0d", n, FL); end
      for (int i = 0; i < 4; i++) begin
         send_word(w[i]);
         total++;
         if (WrEn_SO !== 1'b1 || Addr_DO !== 5'(i) || PAR_Out_DO !== w[i] || FltRst_RBO !== 1'b0
             || Done_SO !== (i == 3)) begin
            bad++;
            $display("[TB] FAIL basic_write%0d: got wr=%b addr=%0d par=%h fltrst=%b done=%b want wr=1 addr=%0d par=%h fltrst=0 done=%b",
                     i, WrEn_SO, Addr_DO, PAR_Out_DO, FltRst_RBO, Done_SO, i, w[i], (i == 3));
         end
      end
      step();
      total++;
      if (FltRst_RBO !== 1'b1 || Done_SO !== 1'b0 || Busy_SO !== 1'b0 || WrEn_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_after: got fltrst=%b done=%b busy=%b wr=%b want 1 0 0 0", FltRst_RBO, Done_SO, Busy_SO, WrEn_SO);
      end
      total++;
      if (wr_cnt - wr0 != 4 || done_cnt - d0 != 1) begin
         bad++;
         $display("[TB] FAIL basic_counts: got writes=%0d dones=%0d want 4 1", wr_cnt - wr0, done_cnt - d0);
      end
   endtask

   task automatic test_stall();
      int n, wr0;
      wr0 = wr_cnt;
      start_load(5'd1, n);
      send_word(32'hA0);
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (WrEn_SO !== 1'b0 || FltRst_RBO !== 1'b0 || Addr_DO !== 5'd0 || PAR_Out_DO !== 32'hA0) begin
            bad++;
            $display("[TB] FAIL stall_gap%0d: got wr=%b fltrst=%b addr=%0d par=%h want 0 0 0 a0",
                     i, WrEn_SO, FltRst_RBO, Addr_DO, PAR_Out_DO);
         end
      end
      send_word(32'hA1);
      total++;
      if (WrEn_SO !== 1'b1 || Addr_DO !== 5'd1 || PAR_Out_DO !== 32'hA1 || Done_SO !== 1'b1) begin
         bad++;
         $display("[TB] FAIL stall_last: got wr=%b addr=%0d par=%h done=%b want 1 1 a1 1", WrEn_SO, Addr_DO, PAR_Out_DO, Done_SO);
      end
      step();
      total++;
      if (wr_cnt - wr0 != 2) begin bad++; $display("[TB] FAIL stall_writes: got %0d want 2", wr_cnt - wr0); end
   endtask

   task automatic test_abort_last();
      int n, wr0, d0;
      wr0 = wr_cnt; d0 = done_cnt;
      start_load(5'd2, n);
      send_word(32'h51);
      send_word(32'h52);
      Abort_SI = 1'b1;
      send_word(32'h53);
      Abort_SI = 1'b0;
      total++;
      if (WrEn_SO !== 1'b1 || Addr_DO !== 5'd2 || PAR_Out_DO !== 32'h53 || Abrt_SO !== 1'b1
          || Done_SO !== 1'b0 || Busy_SO !== 1'b0 || FltRst_RBO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_last: got wr=%b addr=%0d par=%h abrt=%b done=%b busy=%b fltrst=%b want 1 2 53 1 0 0 0",
                  WrEn_SO, Addr_DO, PAR_Out_DO, Abrt_SO, Done_SO, Busy_SO, FltRst_RBO);
      end
      step();
      total++;
      if (Abrt_SO !== 1'b0 || FltRst_RBO !== 1'b1 || Busy_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_after: got abrt=%b fltrst=%b busy=%b want 0 1 0", Abrt_SO, FltRst_RBO, Busy_SO);
      end
      total++;
      if (wr_cnt - wr0 != 3 || done_cnt - d0 != 0) begin
         bad++;
         $display("[TB] FAIL abort_counts: got writes=%0d dones=%0d want 3 0", wr_cnt - wr0, done_cnt - d0);
      end
   endtask

   task automatic test_ignored();
      int n;
      start_load(5'd3, n);
      send_word(32'h61);
      send_word(32'h62);
      Start_SI = 1'b1;
      Len_DI = 5'd0;
      step();
      Start_SI = 1'b0;
      total++;
      if (Busy_SO !== 1'b1 || CofRdy_SO !== 1'b1 || WrEn_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ignore_start_busy: got busy=%b rdy=%b wr=%b want 1 1 0", Busy_SO, CofRdy_SO, WrEn_SO);
      end
      send_word(32'h63);
      total++;
      if (Addr_DO !== 5'd2 || Done_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ignore_continue: got addr=%0d done=%b want 2 0", Addr_DO, Done_SO);
      end
      send_word(32'h64);
      total++;
      if (Addr_DO !== 5'd3 || PAR_Out_DO !== 32'h64 || Done_SO !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ignore_finish: got addr=%0d par=%h done=%b want 3 64 1", Addr_DO, PAR_Out_DO, Done_SO);
      end
      step();
      Start_SI = 1'b1;
      Abort_SI = 1'b1;
      step();
      total++;
      if (Busy_SO !== 1'b0 || FltRst_RBO !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ignore_start_abort: got busy=%b fltrst=%b want 0 1", Busy_SO, FltRst_RBO);
      end
      step();
      Start_SI = 1'b0;
      Abort_SI = 1'b0;
      total++;
      if (Busy_SO !== 1'b0 || CofRdy_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ignore_start_abort2: got busy=%b rdy=%b want 0 0", Busy_SO, CofRdy_SO);
      end
   endtask

   task automatic test_full_range();
      int n, wr0;
      logic [31:0] d;
      wr0 = wr_cnt;
      start_load(5'd31, n);
      for (int i = 0; i < 32; i++) begin
         d = 32'hC000_0000 + 32'(i);
         send_word(d);
         total++;
         if (WrEn_SO !== 1'b1 || Addr_DO !== 5'(i) || PAR_Out_DO !== d || Done_SO !== (i == 31)) begin
            bad++;
            $display("[TB] FAIL full_write%0d: got wr=%b addr=%0d par=%h done=%b want 1 %0d %h %b",
                     i, WrEn_SO, Addr_DO, PAR_Out_DO, Done_SO, i, d, (i == 31));
         end
      end
      step();
      total++;
      if (wr_cnt - wr0 != 32 || Busy_SO !== 1'b0 || WrEn_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL full_after: got writes=%0d busy=%b wr=%b want 32 0 0", wr_cnt - wr0, Busy_SO, WrEn_SO);
      end
   endtask

   task automatic test_len_zero();
      int n, wr0;
      wr0 = wr_cnt;
      start_load(5'd0, n);
      send_word(32'h77);
      total++;
      if (WrEn_SO !== 1'b1 || Addr_DO !== 5'd0 || PAR_Out_DO !== 32'h77 || Done_SO !== 1'b1) begin
         bad++;
         $display("[TB] FAIL len0_write: got wr=%b addr=%0d par=%h done=%b want 1 0 77 1", WrEn_SO, Addr_DO, PAR_Out_DO, Done_SO);
      end
      step();
      total++;
      if (wr_cnt - wr0 != 1 || FltRst_RBO !== 1'b1 || Busy_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL len0_after: got writes=%0d fltrst=%b busy=%b want 1 1 0", wr_cnt - wr0, FltRst_RBO, Busy_SO);
      end
   endtask

   task automatic test_reset_mid_load();
      int n, d0, a0;
      start_load(5'd3, n);
      send_word(32'h81);
      send_word(32'h82);
      d0 = done_cnt; a0 = abrt_cnt;
      CofVld_SI = 1'b1;
      Cof_DI = 32'h83;
      Rst_RI = 1'b1;
      #1;
      total++;
      if ({WrEn_SO, Addr_DO, PAR_Out_DO, CofRdy_SO, Busy_SO, Done_SO, Abrt_SO, FltRst_RBO} !== '0) begin
         bad++;
         $display("[TB] FAIL midrst_async: got wr=%b addr=%0d par=%h rdy=%b busy=%b done=%b abrt=%b fltrst=%b want all 0",
                  WrEn_SO, Addr_DO, PAR_Out_DO, CofRdy_SO, Busy_SO, Done_SO, Abrt_SO, FltRst_RBO);
      end
      step();
      step();
      CofVld_SI = 1'b0;
      Rst_RI = 1'b0;
      #1;
      total++;
      if (FltRst_RBO !== 1'b0) begin bad++; $display("[TB] FAIL midrst_release: got %b want 0", FltRst_RBO); end
      step();
      total++;
      if (FltRst_RBO !== 1'b1 || Busy_SO !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrst_rise: got fltrst=%b busy=%b want 1 0", FltRst_RBO, Busy_SO);
      end
      total++;
      if (done_cnt != d0 || abrt_cnt != a0) begin
         bad++;
         $display("[TB] FAIL midrst_pulses: got dones=%0d abrts=%0d want 0 0", done_cnt - d0, abrt_cnt - a0);
      end
   endtask

   task automatic test_fltrst_invariant();
      total++;
      if (viol != 0) begin bad++; $display("[TB] FAIL fltrst_invariant: got %0d violating cycles want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_stall();
      test_abort_last();
      test_ignored();
      test_full_range();
      test_len_zero();
      test_reset_mid_load();
      test_fltrst_invariant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
